// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC / branch unit: FSM state encoding and default PC constants.
package pc_defs;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_BUBBLE = 2'd2,
    S_HALT   = 2'd3
  } pc_state_e;

  localparam int          PC_W     = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_INC   = 16'd2;
  localparam logic [15:0] TRAP_VEC = 16'h0010;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target adder: base + pre-shifted offset, wrapping modulo 2^WIDTH.
module branch_target_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] off_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = base_i + off_i;

endmodule

// File: rtl/pc_branch_unit.sv
// PC register and next-PC selector with boot/run/bubble/halt sequencing.
// Build option: PC_ALIGN_CHECK_EN traps odd targets to TRAP_VEC instead of clearing bit 0.
module pc_branch_unit
  import pc_defs::*;
#(
  parameter int               WIDTH    = PC_W,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(pc_defs::RESET_PC),
  parameter logic [WIDTH-1:0] PC_INC   = WIDTH'(pc_defs::PC_INC),
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(pc_defs::TRAP_VEC)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_base_pc,
  input  logic [WIDTH-1:0] br_offset_sh,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             halt_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             fetch_valid,
  output logic             redirect,
  output logic             trap
);

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic             trap_q, trap_d;
  logic [WIDTH-1:0] br_sum, tgt_raw;
  logic             misalign;

  branch_target_adder #(.WIDTH(WIDTH)) u_adder (
    .base_i (br_base_pc),
    .off_i  (br_offset_sh),
    .sum_o  (br_sum)
  );

  assign tgt_raw  = jmp ? jmp_target : br_sum;
  assign misalign = ALIGN_CHK && tgt_raw[0];
  assign pc_plus  = pc_q + PC_INC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    trap_d     = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN, S_BUBBLE: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (jmp || br_taken) begin
          // redirect beats stall / imem_ready: the flush must not be held off
          state_d    = S_BUBBLE;
          redirect_d = 1'b1;
          trap_d     = misalign;
          pc_d       = misalign ? TRAP_VEC : {tgt_raw[WIDTH-1:1], 1'b0};
        end else begin
          state_d = S_RUN;
          if (!stall && imem_ready) pc_d = pc_plus;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      trap_q     <= trap_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = (state_q == S_RUN);
  assign redirect    = redirect_q;
  assign trap        = trap_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus randomized traffic vs a behavioural model.
module tb_pc_branch_unit;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, imem_ready, br_taken, jmp, halt_req;
  logic [15:0] br_base_pc, br_offset_sh, jmp_target;
  logic [15:0] pc, pc_plus;
  logic        fetch_valid, redirect, trap;

  int errs = 0;
  int checks = 0;

  // reference model state
  logic [15:0] m_pc;
  bit          m_boot, m_halt, m_bubble, m_rd, m_tr;

  always #5 clk = ~clk;

  pc_branch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .imem_ready(imem_ready),
    .br_taken(br_taken), .br_base_pc(br_base_pc), .br_offset_sh(br_offset_sh),
    .jmp(jmp), .jmp_target(jmp_target), .halt_req(halt_req),
    .pc(pc), .pc_plus(pc_plus), .fetch_valid(fetch_valid),
    .redirect(redirect), .trap(trap)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},  32'(pc), 32'(m_pc));
    chk({tag, ".pcp"}, 32'(pc_plus), 32'((int'(m_pc) + 2) % 65536));
    chk({tag, ".fv"},  32'(fetch_valid), 32'(!m_boot && !m_halt && !m_bubble));
    chk({tag, ".rd"},  32'(redirect), 32'(m_rd));
    chk({tag, ".tr"},  32'(trap), 32'(m_tr));
  endtask

  task automatic clr_in();
    stall = 0; imem_ready = 1; br_taken = 0; jmp = 0; halt_req = 0;
    br_base_pc = 0; br_offset_sh = 0; jmp_target = 0;
  endtask

  // one clock: predict from the current inputs, then compare after the edge
  task automatic step(input string tag);
    int tgt;
    m_rd = 0; m_tr = 0;
    if (m_halt) begin
    end else if (m_boot) begin
      m_boot = 0;
    end else if (halt_req) begin
      m_halt = 1; m_bubble = 0;
    end else if (jmp || br_taken) begin
      tgt = jmp ? int'(jmp_target) : (int'(br_base_pc) + int'(br_offset_sh)) % 65536;
      m_rd = 1; m_bubble = 1;
      if (ALIGN && (tgt % 2 == 1)) begin
        m_pc = 16'h0010; m_tr = 1;
      end else begin
        m_pc = 16'(tgt - (tgt % 2));
      end
    end else begin
      m_bubble = 0;
      if (!stall && imem_ready) m_pc = 16'((int'(m_pc) + 2) % 65536);
    end
    @(posedge clk); #1;
    chk_model(tag);
  endtask

  // asynchronous reset asserted mid-cycle, released one edge later
  task automatic do_reset(input string tag);
    #2 reset_n = 0;
    #1;
    m_pc = 16'h0000; m_boot = 1; m_halt = 0; m_bubble = 0; m_rd = 0; m_tr = 0;
    chk_model({tag, ".async"});
    @(posedge clk); #1;
    chk_model({tag, ".held"});
    reset_n = 1;
  endtask

  initial begin
    clr_in();
    reset_n = 0;
    m_pc = 0; m_boot = 1; m_halt = 0; m_bubble = 0; m_rd = 0; m_tr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_model("rst");
    reset_n = 1;

    // 1: boot sequence
    #1 chk_model("boot");
    step("t1a"); chk("t1a.pc", 32'(pc), 32'h0000); chk("t1a.fv", 32'(fetch_valid), 1);
    step("t1b"); chk("t1b.pc", 32'(pc), 32'h0002);
    step("t1c"); chk("t1c.pc", 32'(pc), 32'h0004);

    // 2: backward branch
    br_taken = 1; br_base_pc = 16'h0010; br_offset_sh = 16'hFFF8;
    step("t2a"); chk("t2a.pc", 32'(pc), 32'h0008); chk("t2a.rd", 32'(redirect), 1);
    chk("t2a.fv", 32'(fetch_valid), 0);
    clr_in();
    step("t2b"); chk("t2b.rd", 32'(redirect), 0);
    step("t2c"); chk("t2c.fv", 32'(fetch_valid), 1);

    // 3: jump beats branch and stall
    jmp = 1; jmp_target = 16'h0100; br_taken = 1; br_base_pc = 16'h0040;
    br_offset_sh = 16'h0020; stall = 1;
    step("t3"); chk("t3.pc", 32'(pc), 32'h0100); chk("t3.rd", 32'(redirect), 1);
    clr_in();
    step("t3b");

    // 4: wrap and imem hold
    jmp = 1; jmp_target = 16'hFFFE;
    step("t4a"); chk("t4a.pc", 32'(pc), 32'hFFFE);
    clr_in();
    step("t4b"); chk("t4b.pc", 32'(pc), 32'h0000);
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step("t4h"); chk("t4h.pc", 32'(pc), 32'h0000);
    end
    clr_in();
    step("t4c"); chk("t4c.pc", 32'(pc), 32'h0002);

    // 5: odd target
    jmp = 1; jmp_target = 16'h0103;
    step("t5");
    chk("t5.pc", 32'(pc), ALIGN ? 32'h0010 : 32'h0102);
    chk("t5.tr", 32'(trap), ALIGN ? 32'd1 : 32'd0);
    clr_in();
    step("t5b"); chk("t5b.tr", 32'(trap), 0);

    // 6: halt is sticky, then async reset
    jmp = 1; jmp_target = 16'h0020;
    step("t6a");
    clr_in(); halt_req = 1;
    step("t6b"); chk("t6b.pc", 32'(pc), 32'h0020); chk("t6b.fv", 32'(fetch_valid), 0);
    clr_in(); jmp = 1; jmp_target = 16'h0300; br_taken = 1;
    step("t6c"); step("t6d");
    chk("t6d.pc", 32'(pc), 32'h0020); chk("t6d.fv", 32'(fetch_valid), 0);
    clr_in();
    do_reset("t6r");
    chk("t6r.pc", 32'(pc), 32'h0000);
    step("t6e"); step("t6f");

    // mid-run reset drops a pending redirect
    jmp = 1; jmp_target = 16'h0444;
    step("t7a"); clr_in();
    do_reset("t7r");
    chk("t7r.rd", 32'(redirect), 0);
    step("t7b");

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      stall        = ($urandom % 4) == 0;
      imem_ready   = ($urandom % 5) != 0;
      br_taken     = ($urandom % 4) == 0;
      jmp          = ($urandom % 7) == 0;
      halt_req     = ($urandom % 60) == 0;
      br_base_pc   = 16'($urandom) & 16'hFFFE;
      br_offset_sh = 16'($urandom);
      jmp_target   = 16'($urandom);
      step("rnd");
      if ((m_halt && ($urandom % 4) == 0) || ($urandom % 120) == 0) begin
        clr_in();
        do_reset("rndr");
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
